led_pattern_engine: RTL

//  Downstream consumer of the IP_AXI_LEDS AXI4-Lite register bank. Turns the four 32-bit config words
//  (slv_reg0..3) into NUM_LEDS physical LED drives: static, blink, rotate and bounce patterns,

---
 rtl/led_pattern_pkg.sv | 28 ++
 rtl/led_pattern_engine_timer.sv | 29 ++
 rtl/led_pattern_engine.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/led_pattern_pkg.sv
// Shared types and bit positions for the LED pattern engine.
// Field offsets below match the AXI register map of the control and status words.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SHIFT  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_INV      = 3;

  localparam int STAT_RUN      = 0;
  localparam int STAT_PEND     = 1;
  localparam int STAT_MODE_LSB = 2;
  localparam int STAT_STEP_LSB = 8;
  localparam int STAT_LED_LSB  = 16;

endpackage

// File: rtl/led_pattern_engine_timer.sv
// Step prescaler: counts 0..max(period,1)-1 while running, tick pulses in the wrap cycle.
// Clear has priority over run; the tick is combinational from the count register.
module led_step_timer (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        i_clr,
  input  logic        i_run,
  input  logic [31:0] i_period,
  output logic        o_tick
);

  logic [31:0] r_cnt;
  logic [31:0] w_last;

  // A zero period behaves like one: the last count is 0, so every cycle ticks.
  assign w_last = (i_period == 32'd0) ? 32'd0 : i_period - 32'd1;
  assign o_tick = i_run & ~i_clr & (r_cnt == w_last);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= o_tick ? 32'd0 : r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// Turns the four LED config words into registered LED drives (static/blink/rotate/bounce with PWM)
// and a registered status word; led_out lags the internal pattern state by one cycle.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [31:0]         cfg_ctrl,
  input  logic [31:0]         cfg_pattern,
  input  logic [31:0]         cfg_period,
  input  logic [31:0]         cfg_duty,
  input  logic                cfg_update,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [31:0]         status
);

  state_t                r_state;
  mode_t                 r_mode_sh;
  logic                  r_inv_sh;
  logic [31:0]           r_period_sh;
  logic [PWM_BITS:0]     r_duty_sh;
  logic [NUM_LEDS-1:0]   r_work;
  logic                  r_phase;
  logic                  r_dir;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [7:0]            r_step_cnt;
  logic                  r_pending;
  logic [NUM_LEDS-1:0]   r_led_out;
  logic [31:0]           r_status;

  state_t                w_state_next;
  mode_t                 w_mode_next;
  logic [NUM_LEDS-1:0]   w_work_next;
  logic                  w_phase_next;
  logic                  w_dir_next;
  logic [PWM_BITS-1:0]   w_pwm_next;
  logic [7:0]            w_step_next;
  logic                  w_pending_next;
  logic [NUM_LEDS-1:0]   w_led_next;
  logic [31:0]           w_status_next;

  logic                  w_en;
  logic                  w_tick;
  logic                  w_pwm_on;
  logic [NUM_LEDS-1:0]   w_rotl;
  logic                  w_bounce_hold;
  logic                  w_unused;

  assign w_en          = cfg_ctrl[CTRL_EN];
  assign w_pwm_on      = ({1'b0, r_pwm_cnt} < r_duty_sh);
  assign w_rotl        = (r_work << 1) | (r_work >> (NUM_LEDS - 1));
  assign w_bounce_hold = (r_work == '0) | (r_work[NUM_LEDS-1] & r_work[0]);
  assign w_mode_next   = (r_state == LOAD) ? mode_t'(cfg_ctrl[CTRL_MODE_LSB +: 2]) : r_mode_sh;
  assign w_unused      = ^{cfg_ctrl[31:4], cfg_pattern[31:NUM_LEDS], cfg_duty[31:PWM_BITS+1]};

  led_step_timer u_timer (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .i_clr    (r_state == LOAD),
    .i_run    (r_state == RUN),
    .i_period (r_period_sh),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_state_next   = r_state;
    w_work_next    = r_work;
    w_phase_next   = r_phase;
    w_dir_next     = r_dir;
    w_pwm_next     = r_pwm_cnt;
    w_step_next    = r_step_cnt;
    w_pending_next = r_pending | cfg_update;
    w_led_next     = {NUM_LEDS{r_inv_sh}};
    case (r_state)
      IDLE: begin
        if (w_en) w_state_next = LOAD;
      end
      LOAD: begin
        w_state_next   = RUN;
        w_work_next    = cfg_pattern[NUM_LEDS-1:0];
        w_phase_next   = 1'b1;
        w_dir_next     = 1'b0;
        w_pwm_next     = '0;
        w_step_next    = '0;
        // An update landing on the LOAD cycle itself still forces a reload.
        w_pending_next = cfg_update;
      end
      RUN: begin
        w_pwm_next = r_pwm_cnt + PWM_BITS'(1);
        w_led_next = (r_work & {NUM_LEDS{r_phase}} & {NUM_LEDS{w_pwm_on}}) ^ {NUM_LEDS{r_inv_sh}};
        if (!w_en) begin
          w_state_next = IDLE;
        end else if (w_tick && r_pending) begin
          w_state_next = LOAD;
        end
        if (w_tick && !r_pending) begin
          w_step_next = r_step_cnt + 8'd1;
          case (r_mode_sh)
            MODE_BLINK: w_phase_next = ~r_phase;
            MODE_SHIFT: w_work_next = w_rotl;
            MODE_BOUNCE: begin
              if (!w_bounce_hold) begin
                if (!r_dir) begin
                  if (r_work[NUM_LEDS-1]) begin
                    w_dir_next  = 1'b1;
                    w_work_next = r_work >> 1;
                  end else begin
                    w_work_next = r_work << 1;
                  end
                end else begin
                  if (r_work[0]) begin
                    w_dir_next  = 1'b0;
                    w_work_next = r_work << 1;
                  end else begin
                    w_work_next = r_work >> 1;
                  end
                end
              end
            end
            default: ;
          endcase
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Status reflects the values the registers take at the same edge, so it tracks led_out exactly.
  always_comb begin
    w_status_next                              = '0;
    w_status_next[STAT_RUN]                    = (w_state_next == RUN);
    w_status_next[STAT_PEND]                   = w_pending_next;
    w_status_next[STAT_MODE_LSB +: 2]          = w_mode_next;
    w_status_next[STAT_STEP_LSB +: 8]          = w_step_next;
    w_status_next[STAT_LED_LSB +: NUM_LEDS]    = w_led_next;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= IDLE;
      r_mode_sh   <= MODE_STATIC;
      r_inv_sh    <= 1'b0;
      r_period_sh <= '0;
      r_duty_sh   <= '0;
      r_work      <= '0;
      r_phase     <= 1'b0;
      r_dir       <= 1'b0;
      r_pwm_cnt   <= '0;
      r_step_cnt  <= '0;
      r_pending   <= 1'b0;
      r_led_out   <= '0;
      r_status    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_mode_sh  <= w_mode_next;
      r_work     <= w_work_next;
      r_phase    <= w_phase_next;
      r_dir      <= w_dir_next;
      r_pwm_cnt  <= w_pwm_next;
      r_step_cnt <= w_step_next;
      r_pending  <= w_pending_next;
      r_led_out  <= w_led_next;
      r_status   <= w_status_next;
      if (r_state == LOAD) begin
        r_inv_sh    <= cfg_ctrl[CTRL_INV];
        r_period_sh <= cfg_period;
        r_duty_sh   <= cfg_duty[PWM_BITS:0];
      end
    end
  end

  assign led_out = r_led_out;
  assign status  = r_status;

endmodule
